reg_bus_arbiter: RTL
====================

# reg_bus_arbiter

- N-master to 1-slave arbiter for the single-phase register bus (addr/write/wdata/wstrb/valid requests; rdata/error/ready responses).
- Round-robin arbitration grants one master at a time and holds the grant for the whole transaction. Request fields are forwarded unchanged; the response goes back only to the granted master.
- Sits between several configuration masters (debug module, CPU peripheral port, DMA) and one shared register-file or peripheral crossbar.

## Interface
Parameters:
- N_MST, 2: number of upstream masters (≥2).
- ADDR_WIDTH, 32: request address width.
- DATA_WIDTH, 32: data width, multiple of 8; strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256: wait-cycle limit for the slave (used only with REG_BUS_ARB_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock; everything is sampled on its rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- mst_valid_i  in  N_MST  per-master request valid.
- mst_addr_i  in  N_MST×ADDR_WIDTH  per-master address.
- mst_write_i  in  N_MST  per-master write flag (1=write).
- mst_wdata_i  in  N_MST×DATA_WIDTH  per-master write data.
- mst_wstrb_i  in  N_MST×DATA_WIDTH/8  per-master byte strobe.
- mst_ready_o  out  N_MST  per-master completion.
- mst_rdata_o  out  N_MST×DATA_WIDTH  per-master read data; 0 when the master is not granted.
- mst_error_o  out  N_MST  per-master error; 0 when the master is not granted.
- slv_valid_o, slv_addr_o, slv_write_o, slv_wdata_o, slv_wstrb_o  out  request to the slave.
- slv_rdata_i, slv_error_i, slv_ready_i  in  response from the slave.
- grant_o  out  $clog2(N_MST)  index of the current or last grant.
- busy_o  out  1  high while in BUSY.
- timeout_o  out  1  one-cycle pulse when a transaction is aborted.

## Operation
FSM states: IDLE and BUSY.

IDLE:
- All slv_* outputs and mst_ready_o are 0.
- If any mst_valid_i is high, select the first requesting index scanning from last_q+1, wrapping modulo N_MST.
- Register the selection in grant_q and go to BUSY.

BUSY:
- slv_valid_o = mst_valid_i[grant_q]; slv_addr/write/wdata/wstrb are driven combinationally from master grant_q.
- mst_ready_o[grant_q] = slv_ready_i. mst_rdata_o[grant_q] and mst_error_o[grant_q] follow the slave. All other masters see 0.
- Handshake (slv_valid_o && slv_ready_i): last_q ← grant_q, go to IDLE.
- If the granted master drops valid (protocol violation): go to IDLE; last_q is unchanged.

Other rules:
- Requests from non-granted masters stay pending; their ready is 0.
- In IDLE, slv_addr_o, slv_wdata_o and slv_wstrb_o are 0.
- Reset: state=IDLE, grant_q=0, last_q=N_MST-1 (master 0 has first priority), timeout counter=0, every output 0.
- Reset asserted mid-transaction aborts the transaction immediately with no response.

## Timing
- One arbitration cycle, then the slave sees the request: slv_valid_o rises 1 cycle after mst_valid_i.
- Zero-wait slave: ready returns to the master in the cycle after the grant. Total latency is 2 cycles.
- Back-to-back throughput is one transaction per 2 cycles; there is a mandatory IDLE cycle between grants.
- Wrap-around: after master N_MST-1 completes, index 0 is searched first.
- A master that re-requests in the cycle its transaction completes gets its next grant only after every other pending master has been served once.

## Configuration
REG_BUS_ARB_TIMEOUT_EN defined:
- A counter clears on entry to BUSY and increments on each BUSY cycle with slv_ready_i low.
- When the counter reaches TIMEOUT_CYCLES, in that same cycle:
  - drive mst_ready_o[grant_q]=1, mst_error_o[grant_q]=1 and mst_rdata_o[grant_q]=0;
  - drop slv_valid_o;
  - pulse timeout_o;
  - set last_q ← grant_q and go to IDLE.
- Counter width is $clog2(TIMEOUT_CYCLES+1).

REG_BUS_ARB_TIMEOUT_EN undefined:
- No counter is built and timeout_o is tied to 0.
- BUSY waits indefinitely for slv_ready_i.

## Structure
- Package reg_bus_arb_pkg holds:
  - state enum arb_state_e {IDLE, BUSY};
  - helper function idx_width(n) = max(1, $clog2(n)).
- Sub-module reg_bus_arb_rr_pick (combinational) takes req[N_MST] and last index, and returns gnt index and any_req.
- The top level owns the FSM, grant_q and last_q registers, the optional timeout counter, and the request/response muxes.

## Test plan
- Single request, N_MST=4: master 2 writes addr 0x10, wdata 0xDEADBEEF, wstrb 0xF; slave ready immediate → slv_valid_o at cycle 1, mst_ready_o[2] at cycle 1, grant_o=2; other masters see ready=0 and rdata=0.
- Round-robin: all 4 masters request continuously, zero-wait slave → grant sequence 0,1,2,3,0,…; one completion every 2 cycles.
- Wait states: slave holds ready low for 5 cycles on a read returning rdata 0x1234, error=1 → master 1 sees ready, rdata 0x1234 and error=1 only in cycle 6 of BUSY; all request fields stay stable.
- Timeout (macro on, TIMEOUT_CYCLES=8): slave never ready → on the 8th wait cycle mst_ready_o and mst_error_o pulse for the granted master, timeout_o pulses, FSM returns to IDLE; with the macro off, busy_o stays high.
- Reset mid-BUSY: assert rst_i during a waited transaction → all outputs 0 asynchronously. After release, master 0 wins when masters 0 and 3 both request.
- Violation: granted master drops valid in BUSY → IDLE next cycle; the same master wins again if it re-requests alone.

Source files
------------

// File: rtl/reg_bus_arb_pkg.sv
// Shared types and helpers for the register-bus arbiter.
// Optional feature macro: REG_BUS_ARB_TIMEOUT_EN (slave wait-cycle timeout).
package reg_bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_bus_arb_rr_pick.sv
// Round-robin picker: first requesting index after i_last, wrapping modulo N_MST.
module reg_bus_arb_rr_pick
  import reg_bus_arb_pkg::*;
#(
  parameter int N_MST = 2,
  parameter int IW    = idx_width(N_MST)
) (
  input  logic [N_MST-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [IW-1:0]    o_gnt,
  output logic             o_any
);

  // Scan from farthest to nearest so the nearest requester after i_last wins.
  always_comb begin
    int v_idx;
    v_idx = 0;
    o_gnt = '0;
    o_any = 1'b0;
    for (int k = N_MST; k >= 1; k--) begin
      v_idx = (int'(i_last) + k) % N_MST;
      if (i_req[IW'(v_idx)]) begin
        o_gnt = IW'(v_idx);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// N-master to 1-slave register-bus arbiter with round-robin grant held for
// a whole transaction. Optional slave timeout under REG_BUS_ARB_TIMEOUT_EN.
//
// Handshake: a transaction completes in the cycle where slv_valid_o and
// slv_ready_i are both high; mst_ready_o of the granted master mirrors
// slv_ready_i during BUSY. Dropping valid while granted aborts back to IDLE
// without advancing the round-robin pointer. busy_o exposes the FSM state.
module reg_bus_arbiter
  import reg_bus_arb_pkg::*;
#(
  parameter int N_MST          = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [N_MST-1:0]                mst_valid_i,
  input  logic [N_MST*ADDR_WIDTH-1:0]     mst_addr_i,
  input  logic [N_MST-1:0]                mst_write_i,
  input  logic [N_MST*DATA_WIDTH-1:0]     mst_wdata_i,
  input  logic [N_MST*DATA_WIDTH/8-1:0]   mst_wstrb_i,
  output logic [N_MST-1:0]                mst_ready_o,
  output logic [N_MST*DATA_WIDTH-1:0]     mst_rdata_o,
  output logic [N_MST-1:0]                mst_error_o,
  output logic                            slv_valid_o,
  output logic [ADDR_WIDTH-1:0]           slv_addr_o,
  output logic                            slv_write_o,
  output logic [DATA_WIDTH-1:0]           slv_wdata_o,
  output logic [DATA_WIDTH/8-1:0]         slv_wstrb_o,
  input  logic [DATA_WIDTH-1:0]           slv_rdata_i,
  input  logic                            slv_error_i,
  input  logic                            slv_ready_i,
  output logic [idx_width(N_MST)-1:0]     grant_o,
  output logic                            busy_o,
  output logic                            timeout_o
);

  localparam int IW = idx_width(N_MST);
  localparam int SW = DATA_WIDTH / 8;

  arb_state_e          r_state, w_state_nxt;
  logic [IW-1:0]       r_grant, r_last, w_pick;
  logic                w_any, w_last_ld, w_tmo, w_valid_g;
  logic                w_rsp_ready, w_rsp_err;
  logic [DATA_WIDTH-1:0] w_rsp_rdata;
  logic [N_MST-1:0]    w_gsel;

  logic [ADDR_WIDTH-1:0] w_addr  [N_MST];
  logic [DATA_WIDTH-1:0] w_wdata [N_MST];
  logic [SW-1:0]         w_wstrb [N_MST];

  // Unpack flat master buses and fan the granted response back out.
  for (genvar i = 0; i < N_MST; i++) begin : g_mst
    assign w_addr[i]  = mst_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[i] = mst_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_wstrb[i] = mst_wstrb_i[i*SW +: SW];
    assign w_gsel[i]  = (r_state == BUSY) && (r_grant == IW'(i));
    assign mst_ready_o[i] = w_gsel[i] & w_rsp_ready;
    assign mst_error_o[i] = w_gsel[i] & w_rsp_err;
    assign mst_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = w_gsel[i] ? w_rsp_rdata : '0;
  end

  reg_bus_arb_rr_pick #(
    .N_MST (N_MST),
    .IW    (IW)
  ) u_pick (
    .i_req  (mst_valid_i),
    .i_last (r_last),
    .o_gnt  (w_pick),
    .o_any  (w_any)
  );

  assign w_valid_g = mst_valid_i[r_grant];
  assign busy_o    = (r_state == BUSY);
  assign grant_o   = r_grant;
  assign timeout_o = w_tmo;

`ifdef REG_BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt, w_cnt_inc;
  logic          w_cnt_hit;

  assign w_cnt_inc = r_cnt + CW'(1);
  // Fires in the wait cycle that brings the count up to the limit.
  assign w_cnt_hit = (r_state == BUSY) && !slv_ready_i && (w_cnt_inc == CW'(TIMEOUT_CYCLES));

  // Wait-cycle counter: held at zero in IDLE, counts BUSY cycles without ready.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
    end else if (!slv_ready_i) begin
      r_cnt <= w_cnt_inc;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= IW'(N_MST - 1);
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && w_any) r_grant <= w_pick;
      if (w_last_ld) r_last <= r_grant;
    end
  end

  // Next-state logic plus request forwarding and granted response selection.
  always_comb begin
    w_state_nxt = r_state;
    w_last_ld   = 1'b0;
    w_tmo       = 1'b0;
    slv_valid_o = 1'b0;
    slv_addr_o  = '0;
    slv_write_o = 1'b0;
    slv_wdata_o = '0;
    slv_wstrb_o = '0;
    w_rsp_ready = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_rdata = '0;
    case (r_state)
      IDLE: begin
        if (w_any) w_state_nxt = BUSY;
      end
      BUSY: begin
        slv_valid_o = w_valid_g;
        slv_addr_o  = w_addr[r_grant];
        slv_write_o = mst_write_i[r_grant];
        slv_wdata_o = w_wdata[r_grant];
        slv_wstrb_o = w_wstrb[r_grant];
        w_rsp_ready = slv_ready_i;
        w_rsp_err   = slv_error_i;
        w_rsp_rdata = slv_rdata_i;
        if (w_valid_g && slv_ready_i) begin
          w_state_nxt = IDLE;
          w_last_ld   = 1'b1;
        end else if (!w_valid_g) begin
          w_state_nxt = IDLE;
`ifdef REG_BUS_ARB_TIMEOUT_EN
        end else if (w_cnt_hit) begin
          slv_valid_o = 1'b0;
          w_rsp_ready = 1'b1;
          w_rsp_err   = 1'b1;
          w_rsp_rdata = '0;
          w_tmo       = 1'b1;
          w_last_ld   = 1'b1;
          w_state_nxt = IDLE;
`endif
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
